aes_key_sched_ctrl: RTL and testbench

//  Sequences AES-128 key expansion iteratively, one round key per clock, through a combinational step unit.

---
 rtl/aes_pkg.sv | 41 ++++
 rtl/aes_key_step.sv | 35 +++
 rtl/aes_sub_byte.sv | 28 ++
 rtl/aes_key_sched_ctrl.sv | 142 ++++++++++++++
 tb/tb_aes_key_sched_ctrl.sv | 421 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_pkg.sv
// Shared AES key-schedule types, constants and GF(2^8) helpers.
package aes_pkg;

    localparam int unsigned AES_NR  = 10;
    localparam int unsigned KEY_W   = 128;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTE_W  = 8;

    localparam logic [BYTE_W-1:0] RCON_INIT   = 8'h01;
    localparam logic [BYTE_W-1:0] RCON_POLY   = 8'h1B;
    localparam logic [BYTE_W-1:0] SBOX_AFFINE = 8'h63;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        READY
    } state_e;

    // Round keys 0..AES_NR, index 0 is the cipher key itself.
    typedef logic [AES_NR:0][KEY_W-1:0] rk_array_t;

    // Multiply by x in GF(2^8); also steps the round constant.
    function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? RCON_POLY : 8'h00);
    endfunction

    // General GF(2^8) multiply, shift-and-add over the AES polynomial.
    function automatic logic [BYTE_W-1:0] gf_mul(input logic [BYTE_W-1:0] a,
                                                 input logic [BYTE_W-1:0] b);
        logic [BYTE_W-1:0] p;
        logic [BYTE_W-1:0] aa;
        p  = '0;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = xtime(aa);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion round: previous round key + rcon -> next round key.
module aes_key_step
    import aes_pkg::*;
(
    input  logic [KEY_W-1:0]  prev_i,
    input  logic [BYTE_W-1:0] rcon_i,
    output logic [KEY_W-1:0]  next_o
);

    logic [WORD_W-1:0] rot_w;
    logic [WORD_W-1:0] sub_w;
    logic [WORD_W-1:0] t_w;
    logic [WORD_W-1:0] n0, n1, n2, n3;

    assign rot_w = {prev_i[23:0], prev_i[31:24]};

    // SubWord over the rotated last word.
    for (genvar g = 0; g < 4; g++) begin : g_sbox
        aes_sub_byte u_sbox (
            .in_i  (rot_w[g*BYTE_W +: BYTE_W]),
            .out_o (sub_w[g*BYTE_W +: BYTE_W])
        );
    end

    // Chained word XORs producing w4..w7 of the new round.
    always_comb begin
        t_w    = sub_w ^ {rcon_i, 24'h0};
        n0     = prev_i[127:96] ^ t_w;
        n1     = prev_i[95:64]  ^ n0;
        n2     = prev_i[63:32]  ^ n1;
        n3     = prev_i[31:0]   ^ n2;
        next_o = {n0, n1, n2, n3};
    end

endmodule

// File: rtl/aes_sub_byte.sv
// AES S-box: multiplicative inverse (x^254) followed by the affine transform.
module aes_sub_byte
    import aes_pkg::*;
(
    input  logic [BYTE_W-1:0] in_i,
    output logic [BYTE_W-1:0] out_o
);

    logic [BYTE_W-1:0] sq;
    logic [BYTE_W-1:0] inv;

    // x^254 = x^2 * x^4 * ... * x^128 gives the inverse (0 maps to 0).
    always_comb begin
        sq  = in_i;
        inv = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        out_o = inv
              ^ {inv[6:0], inv[7]}
              ^ {inv[5:0], inv[7:6]}
              ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]}
              ^ SBOX_AFFINE;
    end

endmodule

// File: rtl/aes_key_sched_ctrl.sv
// AES-128 key schedule controller: iterative expansion, round-key store and
// registered indexed read port. Optional macro AES_KEY_ZEROIZE_EN adds the
// zeroize input and clears key storage on reset.
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES_NR,
    parameter int unsigned IDX_W      = 4
)
(
    input  logic              clk,
    input  logic              reset,
`ifdef AES_KEY_ZEROIZE_EN
    input  logic              zeroize,
`endif
    input  logic [KEY_W-1:0]  key_in,
    input  logic              key_valid,
    output logic              key_ready,
    output logic              keys_ready,
    input  logic              rk_req,
    input  logic [IDX_W-1:0]  rk_idx,
    output logic [KEY_W-1:0]  rk_out,
    output logic              rk_valid,
    output logic              rk_err
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   cnt_q, cnt_d;
    logic [BYTE_W-1:0]  rcon_q, rcon_d;
    rk_array_t          k_q, k_d;
    logic [KEY_W-1:0]   rk_out_q, rk_out_d;
    logic               rk_valid_q, rk_valid_d;
    logic               rk_err_q, rk_err_d;
    logic               key_ready_q, key_ready_d;
    logic               keys_ready_q, keys_ready_d;
    logic [KEY_W-1:0]   step_key;

    aes_key_step u_step (
        .prev_i (k_q[cnt_q - IDX_W'(1)]),
        .rcon_i (rcon_q),
        .next_o (step_key)
    );

    // Control and read-port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            rcon_q       <= RCON_INIT;
            rk_out_q     <= '0;
            rk_valid_q   <= 1'b0;
            rk_err_q     <= 1'b0;
            key_ready_q  <= 1'b1;
            keys_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            rcon_q       <= rcon_d;
            rk_out_q     <= rk_out_d;
            rk_valid_q   <= rk_valid_d;
            rk_err_q     <= rk_err_d;
            key_ready_q  <= key_ready_d;
            keys_ready_q <= keys_ready_d;
        end
    end

    // Round-key storage; only cleared by reset when zeroization is built in.
    always_ff @(posedge clk) begin
`ifdef AES_KEY_ZEROIZE_EN
        if (reset) k_q <= '0;
        else       k_q <= k_d;
`else
        k_q <= k_d;
`endif
    end

    // Next-state, expansion writes and read-port decode.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        rcon_d     = rcon_q;
        k_d        = k_q;
        rk_out_d   = rk_out_q;
        rk_valid_d = 1'b0;
        rk_err_d   = 1'b0;

        case (state_q)
            IDLE, READY: begin
                if (key_valid) begin
                    k_d[0]  = key_in;
                    rcon_d  = RCON_INIT;
                    cnt_d   = IDX_W'(1);
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                k_d[cnt_q] = step_key;
                rcon_d     = xtime(rcon_q);
                if (cnt_q == IDX_W'(NUM_ROUNDS)) begin
                    cnt_d   = '0;
                    state_d = READY;
                end else begin
                    cnt_d = cnt_q + IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        // Reads see the stored set before this cycle's writes.
        if (rk_req) begin
            if (keys_ready_q && (rk_idx <= IDX_W'(NUM_ROUNDS))) begin
                rk_out_d   = k_q[rk_idx];
                rk_valid_d = 1'b1;
            end else begin
                rk_err_d = 1'b1;
            end
        end

`ifdef AES_KEY_ZEROIZE_EN
        // Zeroize wins over key loads and reads.
        if (zeroize) begin
            k_d        = '0;
            rk_out_d   = '0;
            rk_valid_d = 1'b0;
            rk_err_d   = 1'b0;
            cnt_d      = '0;
            rcon_d     = RCON_INIT;
            state_d    = IDLE;
        end
`endif

        key_ready_d  = (state_d != EXPAND);
        keys_ready_d = (state_d == READY);
    end

    assign key_ready  = key_ready_q;
    assign keys_ready = keys_ready_q;
    assign rk_out     = rk_out_q;
    assign rk_valid   = rk_valid_q;
    assign rk_err     = rk_err_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Self-checking bench for aes_key_sched_ctrl against a word-level FIPS-197 model.
module tb_aes_key_sched_ctrl;

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] FIPS_K1  = 128'ha0fafe1788542cb123a339392a6c7605;
    localparam logic [127:0] FIPS_K10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
    localparam logic [127:0] SEQ_KEY  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] SEQ_K10  = 128'h13111d7fe3944a17f307a78b4d2b30c5;

    logic         clk = 1'b0;
    logic         reset;
`ifdef AES_KEY_ZEROIZE_EN
    logic         zeroize;
`endif
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic         keys_ready;
    logic         rk_req;
    logic [3:0]   rk_idx;
    logic [127:0] rk_out;
    logic         rk_valid;
    logic         rk_err;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sbox_t [256];
    logic [7:0]   rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                    8'h20, 8'h40, 8'h80, 8'h1B, 8'h36};
    logic [127:0] model_k [11];
    logic [127:0] exp_out;

    aes_key_sched_ctrl dut (
        .clk        (clk),
        .reset      (reset),
`ifdef AES_KEY_ZEROIZE_EN
        .zeroize    (zeroize),
`endif
        .key_in     (key_in),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .keys_ready (keys_ready),
        .rk_req     (rk_req),
        .rk_idx     (rk_idx),
        .rk_out     (rk_out),
        .rk_valid   (rk_valid),
        .rk_err     (rk_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    // S-box table from the generator-3 walk over GF(2^8).
    task automatic init_sbox();
        logic [7:0] p, q;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1B : 8'h00);
            q = q ^ {q[6:0], 1'b0};
            q = q ^ {q[5:0], 2'b0};
            q = q ^ {q[3:0], 4'b0};
            if (q[7]) q = q ^ 8'h09;
            sbox_t[p] = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4) ^ 8'h63;
        end while (p != 8'h01);
        sbox_t[0] = 8'h63;
    endtask

    // Word-by-word FIPS-197 expansion into model_k.
    task automatic compute_model(input logic [127:0] key);
        logic [31:0] w [44];
        logic [31:0] t;
        for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]}
                    ^ {rcon_tab[i/4 - 1], 24'h0};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) model_k[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // Present a key once key_ready is seen; lat = edges from acceptance to keys_ready.
    task automatic load_key(input logic [127:0] key, output int lat);
        int n;
        n = 0;
        while (!key_ready && n < 40) begin
            tick();
            n++;
        end
        key_in    = key;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        lat = 1;
        while (!keys_ready && lat < 40) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        checks++;
        if (key_ready !== 1'b1 || keys_ready !== 1'b0 || rk_valid !== 1'b0 || rk_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got kr=%b ksr=%b v=%b e=%b want 1 0 0 0",
                     key_ready, keys_ready, rk_valid, rk_err);
        end
        checks++;
        if (rk_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_rk_out: got %h want 0", rk_out);
        end
        reset = 1'b0;
        tick();
        checks++;
        if (key_ready !== 1'b1 || keys_ready !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got kr=%b ksr=%b want 1 0", key_ready, keys_ready);
        end
        exp_out = 128'h0;
    endtask

    task automatic test_fips();
        int lat;
        compute_model(FIPS_KEY);
        checks++;
        if (model_k[1] !== FIPS_K1 || model_k[10] !== FIPS_K10) begin
            errors++;
            $display("FAIL model_fips: got k1=%h k10=%h want %h %h", model_k[1], model_k[10], FIPS_K1, FIPS_K10);
        end
        load_key(FIPS_KEY, lat);
        checks++;
        if (lat !== 11) begin
            errors++;
            $display("FAIL fips_latency: got %0d want 11", lat);
        end
        rk_req = 1'b1;
        rk_idx = 4'd1;
        tick();
        checks++;
        if (rk_valid !== 1'b1 || rk_out !== FIPS_K1) begin
            errors++;
            $display("FAIL fips_k1: got v=%b %h want 1 %h", rk_valid, rk_out, FIPS_K1);
        end
        rk_idx = 4'd10;
        tick();
        rk_req = 1'b0;
        checks++;
        if (rk_valid !== 1'b1 || rk_out !== FIPS_K10) begin
            errors++;
            $display("FAIL fips_k10: got v=%b %h want 1 %h", rk_valid, rk_out, FIPS_K10);
        end
        exp_out = FIPS_K10;
    endtask

    task automatic test_readback();
        rk_req = 1'b1;
        for (int i = 0; i <= 10; i++) begin
            rk_idx = 4'(i);
            tick();
            checks++;
            if (rk_valid !== 1'b1 || rk_err !== 1'b0 || rk_out !== model_k[i]) begin
                errors++;
                $display("FAIL readback_%0d: got v=%b e=%b %h want 1 0 %h", i, rk_valid, rk_err, rk_out, model_k[i]);
            end
        end
        exp_out = model_k[10];
        for (int i = 0; i < 3; i++) begin
            rk_idx = (i == 0) ? 4'd11 : 4'($urandom_range(11, 15));
            tick();
            checks++;
            if (rk_valid !== 1'b0 || rk_err !== 1'b1 || rk_out !== exp_out) begin
                errors++;
                $display("FAIL bad_idx_%0d: got v=%b e=%b %h want 0 1 %h", rk_idx, rk_valid, rk_err, rk_out, exp_out);
            end
        end
        rk_req = 1'b0;
        tick();
        checks++;
        if (rk_valid !== 1'b0 || rk_err !== 1'b0) begin
            errors++;
            $display("FAIL idle_read_port: got v=%b e=%b want 0 0", rk_valid, rk_err);
        end
    endtask

    task automatic test_expand_guard();
        logic [127:0] key, other;
        int n;
        key   = {$urandom, $urandom, $urandom, $urandom};
        other = ~key;
        compute_model(key);
        key_in    = key;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        tick();
        tick();
        checks++;
        if (key_ready !== 1'b0 || keys_ready !== 1'b0) begin
            errors++;
            $display("FAIL expand_flags: got kr=%b ksr=%b want 0 0", key_ready, keys_ready);
        end
        rk_req    = 1'b1;
        rk_idx    = 4'd3;
        key_in    = other;
        key_valid = 1'b1;
        tick();
        rk_req    = 1'b0;
        key_valid = 1'b0;
        checks++;
        if (rk_err !== 1'b1 || rk_valid !== 1'b0 || rk_out !== exp_out) begin
            errors++;
            $display("FAIL expand_read: got e=%b v=%b %h want 1 0 %h", rk_err, rk_valid, rk_out, exp_out);
        end
        n = 0;
        while (!keys_ready && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (keys_ready !== 1'b1) begin
            errors++;
            $display("FAIL expand_timeout: got keys_ready=%b want 1", keys_ready);
        end
        rk_req = 1'b1;
        for (int i = 0; i <= 10; i += 5) begin
            rk_idx = 4'(i);
            tick();
            checks++;
            if (rk_valid !== 1'b1 || rk_out !== model_k[i]) begin
                errors++;
                $display("FAIL ignored_key_%0d: got v=%b %h want 1 %h", i, rk_valid, rk_out, model_k[i]);
            end
        end
        rk_req  = 1'b0;
        exp_out = model_k[10];
    endtask

    task automatic test_reset_mid();
        int lat;
        key_in    = FIPS_KEY;
        key_valid = 1'b1;
        tick();
        key_valid = 1'b0;
        repeat (4) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (keys_ready !== 1'b0 || key_ready !== 1'b1 || rk_out !== 128'h0) begin
            errors++;
            $display("FAIL mid_reset: got ksr=%b kr=%b %h want 0 1 0", keys_ready, key_ready, rk_out);
        end
        rk_req = 1'b1;
        rk_idx = 4'd0;
        tick();
        rk_req = 1'b0;
        checks++;
        if (rk_err !== 1'b1 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_read: got e=%b v=%b want 1 0", rk_err, rk_valid);
        end
        load_key(FIPS_KEY, lat);
        checks++;
        if (lat !== 11) begin
            errors++;
            $display("FAIL reload_latency: got %0d want 11", lat);
        end
        rk_req = 1'b1;
        rk_idx = 4'd10;
        tick();
        rk_req = 1'b0;
        checks++;
        if (rk_valid !== 1'b1 || rk_out !== FIPS_K10) begin
            errors++;
            $display("FAIL reload_k10: got v=%b %h want 1 %h", rk_valid, rk_out, FIPS_K10);
        end
        exp_out = FIPS_K10;
    endtask

    task automatic test_reload_read();
        int n;
        compute_model(SEQ_KEY);
        key_in    = SEQ_KEY;
        key_valid = 1'b1;
        rk_req    = 1'b1;
        rk_idx    = 4'd10;
        tick();
        key_valid = 1'b0;
        rk_req    = 1'b0;
        checks++;
        if (rk_valid !== 1'b1 || rk_out !== FIPS_K10 || keys_ready !== 1'b0 || key_ready !== 1'b0) begin
            errors++;
            $display("FAIL overlap_read: got v=%b %h ksr=%b kr=%b want 1 %h 0 0",
                     rk_valid, rk_out, keys_ready, key_ready, FIPS_K10);
        end
        n = 1;
        while (!keys_ready && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 11) begin
            errors++;
            $display("FAIL overlap_latency: got %0d want 11", n);
        end
        rk_req = 1'b1;
        rk_idx = 4'd10;
        tick();
        checks++;
        if (rk_valid !== 1'b1 || rk_out !== SEQ_K10 || rk_out !== model_k[10]) begin
            errors++;
            $display("FAIL seq_k10: got %h want %h", rk_out, SEQ_K10);
        end
        rk_idx = 4'd0;
        tick();
        rk_req = 1'b0;
        checks++;
        if (rk_valid !== 1'b1 || rk_out !== SEQ_KEY) begin
            errors++;
            $display("FAIL seq_k0: got %h want %h", rk_out, SEQ_KEY);
        end
        exp_out = SEQ_KEY;
    endtask

    task automatic test_random();
        logic [127:0] key;
        int lat;
        for (int r = 0; r < 4; r++) begin
            key = {$urandom, $urandom, $urandom, $urandom};
            compute_model(key);
            load_key(key, lat);
            checks++;
            if (lat !== 11) begin
                errors++;
                $display("FAIL rand_latency_%0d: got %0d want 11", r, lat);
            end
            rk_req = 1'b1;
            for (int j = 0; j < 6; j++) begin
                rk_idx = 4'($urandom_range(0, 10));
                tick();
                checks++;
                if (rk_valid !== 1'b1 || rk_out !== model_k[rk_idx]) begin
                    errors++;
                    $display("FAIL rand_read_%0d_%0d: got v=%b %h want 1 %h", r, rk_idx, rk_valid, rk_out, model_k[rk_idx]);
                end
            end
            rk_req  = 1'b0;
            exp_out = model_k[rk_idx];
        end
    endtask

`ifdef AES_KEY_ZEROIZE_EN
    task automatic test_zeroize();
        zeroize   = 1'b1;
        key_in    = SEQ_KEY;
        key_valid = 1'b1;
        rk_req    = 1'b1;
        rk_idx    = 4'd4;
        tick();
        zeroize   = 1'b0;
        key_valid = 1'b0;
        rk_req    = 1'b0;
        checks++;
        if (keys_ready !== 1'b0 || key_ready !== 1'b1 || rk_out !== 128'h0 || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL zeroize: got ksr=%b kr=%b v=%b %h want 0 1 0 0", keys_ready, key_ready, rk_valid, rk_out);
        end
        tick();
        checks++;
        if (keys_ready !== 1'b0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL zeroize_idle: got ksr=%b kr=%b want 0 1", keys_ready, key_ready);
        end
    endtask
`endif

    initial begin
        reset     = 1'b1;
        key_in    = '0;
        key_valid = 1'b0;
        rk_req    = 1'b0;
        rk_idx    = '0;
`ifdef AES_KEY_ZEROIZE_EN
        zeroize   = 1'b0;
`endif
        exp_out   = '0;
        init_sbox();
        test_reset();
        test_fips();
        test_readback();
        test_expand_guard();
        test_reset_mid();
        test_reload_read();
        test_random();
`ifdef AES_KEY_ZEROIZE_EN
        test_zeroize();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
